dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data-cache controller for the 5-stage CPU's MEM stage. It accepts single-word CPU load and store requests and resolves them against tag and data storage. Misses are served through a 256-bit line interface to physical memory, with a writeback of the dirty victim line before the fill. The block owns the cache FSM and valid/dirty state and drives the tag and data storage arrays.

---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_ctrl_array.sv | 24 ++
 rtl/dcache_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the direct-mapped data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL
  } state_t;

  localparam int LINE_W = 256;
  localparam int LINE_WORDS = LINE_W / 32;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [LINE_WORDS-1:0][31:0] line_words_t;
  typedef logic [$clog2(LINE_WORDS)-1:0] word_sel_t;

endpackage

// File: rtl/dcache_ctrl_array.sv
// rtl/dcache_ctrl_array.sv - storage array with 1-cycle synchronous read, write-first on same-cycle load.
module dcache_ctrl_array
  import dcache_pkg::*;
#(
  parameter int width   = LINE_W,
  parameter int s_index = 3
) (
  input  logic               clk,
  input  logic               read,
  input  logic               load,
  input  logic [s_index-1:0] index,
  input  logic [width-1:0]   din,
  output logic [width-1:0]   dout
);

  logic [width-1:0] mem [2**s_index];

  // Contents are deliberately not reset; the controller's valid bits gate reachability.
  always_ff @(posedge clk) begin
    if (load) mem[index] <= din;
    if (read) dout <= load ? din : mem[index];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller.
// Optional performance counters enabled by DCACHE_PERF_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int s_index  = 3,
  parameter int s_offset = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:0]   mem_address,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_byte_enable,
  output logic [31:0]   mem_rdata,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [31:0]   pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic          pmem_resp,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);

  localparam int num_sets = 2**s_index;
  localparam int tag_w    = 32 - s_index - s_offset;

  state_t state, state_next;

  logic [num_sets-1:0] valid, dirty;
  logic [tag_w-1:0]    tag, tag_out;
  logic [s_index-1:0]  index;
  word_sel_t           word;
  line_t               data_out, data_in, merged;
  line_words_t         words;
  logic [31:0]         cur_word, new_word;
  logic                array_read, tag_load, data_load, hit;
  logic                unused_addr_bits;

  assign tag   = mem_address[31:s_index+s_offset];
  assign index = mem_address[s_index+s_offset-1:s_offset];
  assign word  = mem_address[s_offset-1:2];
  assign unused_addr_bits = ^mem_address[1:0];

  assign hit = valid[index] && (tag_out == tag);

  dcache_ctrl_array #(.width(tag_w), .s_index(s_index)) tag_array (
    .clk   (clk),
    .read  (array_read),
    .load  (tag_load),
    .index (index),
    .din   (tag),
    .dout  (tag_out)
  );

  dcache_ctrl_array #(.width(LINE_W), .s_index(s_index)) data_array (
    .clk   (clk),
    .read  (array_read),
    .load  (data_load),
    .index (index),
    .din   (data_in),
    .dout  (data_out)
  );

  always_comb begin
    words    = data_out;
    cur_word = words[word];
    new_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) new_word[8*b +: 8] = mem_wdata[8*b +: 8];
    end
    words[word] = new_word;
    merged      = words;
  end

  always_comb begin
    state_next   = state;
    array_read   = 1'b0;
    tag_load     = 1'b0;
    data_load    = 1'b0;
    data_in      = merged;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          array_read = 1'b1;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          mem_resp   = 1'b1;
          state_next = IDLE;
          if (mem_read) mem_rdata = cur_word;
          if (mem_write) data_load = 1'b1;
        end else if (valid[index] && dirty[index]) begin
          state_next = WRITEBACK;
        end else begin
          state_next = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_out, index, {s_offset{1'b0}}};
        pmem_wdata   = data_out;
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, index, {s_offset{1'b0}}};
        if (pmem_resp) begin
          tag_load   = 1'b1;
          data_load  = 1'b1;
          data_in    = pmem_rdata;
          // Write-first read of the same index makes the following COMPARE a guaranteed hit.
          array_read = 1'b1;
          state_next = COMPARE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_next;
      if (state == FILL && pmem_resp) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end
      if (state == COMPARE && hit && mem_write) dirty[index] <= 1'b1;
    end
  end

`ifdef DCACHE_PERF_EN
  logic        refill;
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refill   <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      refill <= (state == FILL) && pmem_resp;
      if (state == COMPARE) begin
        if (hit && !refill) hits_q <= hits_q + 32'd1;
        else if (!hit) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign hit_count  = hits_q;
  assign miss_count = misses_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl against a flat-memory reference model.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address, mem_wdata;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count, miss_count;

  dcache_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Backing memory: untouched words follow a fixed pattern; line 0x40 holds 0x1000_0000+i.
  function automatic logic [31:0] default_word(input logic [31:0] a);
    return 32'h1000_0000 + ((a - 32'h40) >> 2);
  endfunction

  logic [255:0] dev_mem [int unsigned];

  function automatic logic [255:0] dev_line(input int unsigned la);
    logic [255:0] l;
    logic [31:0]  wa;
    if (dev_mem.exists(la)) return dev_mem[la];
    for (int i = 0; i < 8; i++) begin
      wa = (la << 5) + 32'(i * 4);
      l[32*i +: 32] = default_word(wa);
    end
    return l;
  endfunction

  // Reference: architectural word memory plus a per-set tag/valid/dirty picture of the cache.
  logic [31:0] ref_mem [int unsigned];
  bit   [7:0]  rv, rd;
  logic [23:0] rt [8];
  int          ref_hits = 0, ref_misses = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
    return default_word({a[31:2], 2'b00});
  endfunction

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    bit          hit;
    bit          wb;
    logic [31:0] wb_addr;
    logic [31:0] fill_addr;
  } exp_t;

  exp_t sb[$];
  bit   done;
  bit   hold;
  int   lat, n_wb, n_fill;
  logic [31:0] wb_seen, fill_seen;

  task automatic issue(input bit rd_op, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    exp_t        e;
    logic [2:0]  idx;
    logic [23:0] tg;
    logic [31:0] w;
    idx = a[7:5];
    tg  = a[31:8];
    e.is_read   = rd_op;
    e.hit       = rv[idx] && (rt[idx] == tg);
    e.wb        = !e.hit && rv[idx] && rd[idx];
    e.wb_addr   = {rt[idx], idx, 5'b0};
    e.fill_addr = {a[31:5], 5'b0};
    if (e.hit) ref_hits++;
    else ref_misses++;
    if (!e.hit) begin
      rv[idx] = 1'b1;
      rt[idx] = tg;
      rd[idx] = 1'b0;
    end
    if (!rd_op) begin
      w = ref_read(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[a >> 2] = w;
      rd[idx] = 1'b1;
    end
    e.rdata = ref_read(a);
    sb.push_back(e);
    done = 1'b0;
    mem_read = rd_op;
    mem_write = !rd_op;
    mem_address = a;
    mem_wdata = wd;
    mem_byte_enable = be;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      #1;
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (!done) begin
      chk("request_timeout", {255'b0, done}, 256'd1);
      finish_sim();
    end
  endtask

  // Memory responder with random latency.
  initial begin
    int wcnt;
    wcnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst) wcnt = 0;
      else if (!hold && (pmem_read || pmem_write)) begin
        if (wcnt == 0) begin
          chk("pmem_addr_align", pmem_address[4:0], 0);
          if (pmem_write) begin
            dev_mem[pmem_address >> 5] = pmem_wdata;
            n_wb++;
            wb_seen = pmem_address;
          end else begin
            pmem_rdata = dev_line(pmem_address >> 5);
            n_fill++;
            fill_seen = pmem_address;
          end
          pmem_resp = 1'b1;
          wcnt = $urandom_range(0, 3);
        end else wcnt--;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a request.
  initial begin
    exp_t e;
    lat = 0; n_wb = 0; n_fill = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat = 0; n_wb = 0; n_fill = 0;
      end else begin
        if (!mem_resp) chk("rdata_zero_without_resp", mem_rdata, 0);
        if (!pmem_write) chk("pmem_wdata_zero", pmem_wdata, 0);
        if (!pmem_read && !pmem_write) chk("pmem_address_zero", pmem_address, 0);
        if (mem_resp) begin
          chk("resp_has_request", {255'b0, sb.size() != 0}, 256'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.is_read) chk("load_data", mem_rdata, e.rdata);
            chk("writebacks", n_wb, e.wb ? 1 : 0);
            chk("fills", n_fill, e.hit ? 0 : 1);
            if (e.hit) chk("hit_latency", lat, 1);
            if (e.wb && n_wb == 1) chk("wb_address", wb_seen, e.wb_addr);
            if (!e.hit && n_fill == 1) chk("fill_address", fill_seen, e.fill_addr);
          end
          lat = 0; n_wb = 0; n_fill = 0;
          done = 1'b1;
        end else if (mem_read || mem_write) lat++;
      end
    end
  end

  task automatic check_counters(input string tag);
`ifdef DCACHE_PERF_EN
    chk({tag, "_hit_count"}, hit_count, ref_hits);
    chk({tag, "_miss_count"}, miss_count, ref_misses);
`else
    chk({tag, "_hit_count"}, hit_count, 0);
    chk({tag, "_miss_count"}, miss_count, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    chk("global_timeout", 0, 1);
    finish_sim();
  end

  initial begin
    logic [31:0] a;
    logic [255:0] l;
    rst = 1'b1;
    hold = 1'b0;
    done = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = '0;
    mem_wdata = '0;
    mem_byte_enable = '0;
    rv = '0;
    rd = '0;
    for (int i = 0; i < 8; i++) rt[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(1'b1, 32'h0000_0040, 32'h0, 4'h0);
    issue(1'b1, 32'h0000_004C, 32'h0, 4'h0);
    issue(1'b0, 32'h0000_0044, 32'hAAAA_BBBB, 4'b0011);
    issue(1'b1, 32'h0000_0044, 32'h0, 4'h0);
    issue(1'b1, 32'h0000_0140, 32'h0, 4'h0);
    l = dev_line(32'h40 >> 5);
    chk("victim_word1", l[63:32], 32'h1000_BBBB);
    @(negedge clk);
    check_counters("seq");

    // Abandon a fill with reset while pmem_read is high.
    hold = 1'b1;
    @(posedge clk);
    #1;
    mem_read = 1'b1;
    mem_address = 32'h0000_0240;
    for (int c = 0; c < 50 && !pmem_read; c++) @(negedge clk);
    chk("abort_reached_fill", pmem_read, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_pmem_read_drop", pmem_read, 0);
    chk("abort_pmem_address", pmem_address, 0);
    mem_read = 1'b0;
    rv = '0;
    rd = '0;
    ref_hits = 0;
    ref_misses = 0;
    @(negedge clk);
    check_counters("abort");
    rst = 1'b0;
    hold = 1'b0;
    @(posedge clk);
    #1;
    issue(1'b1, 32'h0000_0040, 32'h0, 4'h0);

    for (int n = 0; n < 300; n++) begin
      a = {22'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3))};
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    check_counters("final");
    chk("scoreboard_drained", sb.size(), 0);
    finish_sim();
  end

endmodule
